booth_datapath: RTL and testbench

- Datapath for the radix-2 Booth sequential multiplier; sits directly downstream of the multiplier control FSM and is driven cycle by cycle by its control strobes.
- Holds the multiplicand X, the accumulator A, the multiplier/low-product register Y, the Booth history bit Y(-1) and the step counter C.
- Returns the status signals Y0YminusOne and co to the FSM.
- Presents the 2N-bit signed product on a shared N-bit output bus, high half first, then low half.

---
 rtl/booth_datapath.sv | 87 ++++++++
 tb/tb_booth_datapath.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_datapath.sv
// Datapath for the radix-2 Booth sequential multiplier: X, guarded accumulator A,
// multiplier/low-product Y, history bit Y(-1) and step counter C, steered by FSM strobes.
module booth_datapath #(
  parameter int N  = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  inBus,
  input  logic          ldX,
  input  logic          ldY,
  input  logic          ldA,
  input  logic          initA,
  input  logic          initC,
  input  logic          initYminusOne,
  input  logic          aBarS,
  input  logic          shRA,
  input  logic          shRY,
  input  logic          ldYminusOne,
  input  logic          icC,
  input  logic          selL,
  input  logic          selR,
  output logic [1:0]    Y0YminusOne,
  output logic          co,
  output logic [N-1:0]  outBus
);

  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  y_q, y_d;
  logic [N:0]    a_q, a_d;
  logic          ym1_q, ym1_d;
  logic [CW-1:0] c_q, c_d;
  logic [N:0]    sum;

  // A carries a guard sign bit so -2^(N-1) * -2^(N-1) stays exact.
  always_comb begin
    sum = a_q + ({x_q[N-1], x_q} ^ {(N+1){aBarS}}) + {{N{1'b0}}, aBarS};
  end

  always_comb begin
    x_d   = x_q;
    a_d   = a_q;
    y_d   = y_q;
    ym1_d = ym1_q;
    c_d   = c_q;

    if (ldX) x_d = inBus;

    if (initA)     a_d = '0;
    else if (ldA)  a_d = sum;
    else if (shRA) a_d = {a_q[N], a_q[N:1]};

    if (ldY)       y_d = inBus;
    else if (shRY) y_d = {a_q[0], y_q[N-1:1]};

    if (initYminusOne)    ym1_d = 1'b0;
    else if (ldYminusOne) ym1_d = y_q[0];

    if (initC)    c_d = '0;
    else if (icC) c_d = c_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      a_q   <= '0;
      y_q   <= '0;
      ym1_q <= 1'b0;
      c_q   <= '0;
    end else begin
      x_q   <= x_d;
      a_q   <= a_d;
      y_q   <= y_d;
      ym1_q <= ym1_d;
      c_q   <= c_d;
    end
  end

  always_comb begin
    Y0YminusOne = {y_q[0], ym1_q};
    co          = (c_q == CW'(N - 1));
    if (selL)      outBus = a_q[N-1:0];
    else if (selR) outBus = y_q;
    else           outBus = '0;
  end

endmodule

// File: tb/tb_booth_datapath.sv
// Self-checking bench for booth_datapath: directed sequences plus a table of signed
// multiplies run through a behavioural control FSM, checked via an expected-value queue.
module tb_booth_datapath;
  localparam int N  = 8;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] inBus;
  logic ldX, ldY, ldA, initA, initC, initYminusOne, aBarS;
  logic shRA, shRY, ldYminusOne, icC, selL, selR;
  logic [1:0]   Y0YminusOne;
  logic         co;
  logic [N-1:0] outBus;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string nm;
    int    exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
  } vec_t;
  vec_t vecs[5];

  booth_datapath #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .inBus(inBus),
    .ldX(ldX), .ldY(ldY), .ldA(ldA), .initA(initA), .initC(initC),
    .initYminusOne(initYminusOne), .aBarS(aBarS), .shRA(shRA), .shRY(shRY),
    .ldYminusOne(ldYminusOne), .icC(icC), .selL(selL), .selR(selR),
    .Y0YminusOne(Y0YminusOne), .co(co), .outBus(outBus)
  );

  always #5 clk = ~clk;

  task automatic clr();
    ldX = 0; ldY = 0; ldA = 0; initA = 0; initC = 0; initYminusOne = 0;
    aBarS = 0; shRA = 0; shRY = 0; ldYminusOne = 0; icC = 0; selL = 0; selR = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic expect_val(input string nm, input int exp);
    sb_t e;
    e.nm = nm;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input int act);
    sb_t e;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty actual=%0h", act);
    end else begin
      e = sb_q.pop_front();
      if (act != e.exp) begin
        fails++;
        $display("FAIL %s actual=%0h expected=%0h", e.nm, act, e.exp);
      end
    end
  endtask

  task automatic chk_hi(input string nm, input int exp);
    expect_val(nm, exp);
    selL = 1; #1; sb_check(int'(outBus)); selL = 0; #1;
  endtask

  task automatic chk_lo(input string nm, input int exp);
    expect_val(nm, exp);
    selR = 1; #1; sb_check(int'(outBus)); selR = 0; #1;
  endtask

  task automatic init_ops(input logic [N-1:0] x, input logic [N-1:0] y);
    inBus = x; ldX = 1; initA = 1; initC = 1; initYminusOne = 1; tick();
    inBus = y; ldY = 1; tick();
  endtask

  task automatic shift_step();
    shRA = 1; shRY = 1; ldYminusOne = 1; icC = 1; tick();
  endtask

  task automatic run_mult(input vec_t v, input int idx);
    init_ops(v.x, v.y);
    for (int i = 0; i < N; i++) begin
      if (Y0YminusOne == 2'b10) begin
        ldA = 1; aBarS = 1; tick();
      end else if (Y0YminusOne == 2'b01) begin
        ldA = 1; aBarS = 0; tick();
      end
      expect_val($sformatf("mult%0d_co_step%0d", idx, i), (i == N - 1) ? 1 : 0);
      sb_check(int'(co));
      shift_step();
    end
    expect_val($sformatf("mult%0d_co_after", idx), 0);
    sb_check(int'(co));
    chk_hi($sformatf("mult%0d_hi", idx), int'(v.hi));
    chk_lo($sformatf("mult%0d_lo", idx), int'(v.lo));
  endtask

  initial begin
    vecs[0] = '{x: 8'h03, y: 8'h05, hi: 8'h00, lo: 8'h0F};
    vecs[1] = '{x: 8'hFD, y: 8'h05, hi: 8'hFF, lo: 8'hF1};
    vecs[2] = '{x: 8'h80, y: 8'h80, hi: 8'h40, lo: 8'h00};
    vecs[3] = '{x: 8'h7F, y: 8'h80, hi: 8'hC0, lo: 8'h80};
    vecs[4] = '{x: 8'h00, y: 8'h5A, hi: 8'h00, lo: 8'h00};

    clr();
    inBus = '0;
    rst = 1;
    #12;
    rst = 0;
    #3;

    expect_val("reset_y0ym1", 0); sb_check(int'(Y0YminusOne));
    expect_val("reset_co", 0);    sb_check(int'(co));
    expect_val("reset_idle_bus", 0); sb_check(int'(outBus));
    chk_hi("reset_hi", 0);
    chk_lo("reset_lo", 0);

    // Counter: co only at C = N-1, then wraps
    initC = 1; tick();
    for (int k = 0; k < N - 1; k++) begin
      expect_val($sformatf("cnt_co_c%0d", k), 0); sb_check(int'(co));
      icC = 1; tick();
    end
    expect_val("cnt_co_c7", 1); sb_check(int'(co));
    icC = 1; tick();
    expect_val("cnt_co_wrap", 0); sb_check(int'(co));

    // Single Booth step
    init_ops(8'h05, 8'h03);
    expect_val("step_y0ym1_init", 2); sb_check(int'(Y0YminusOne));
    ldA = 1; aBarS = 1; tick();
    chk_hi("step_sub_a", 8'hFB);
    shift_step();
    chk_hi("step_shift_a", 8'hFD);
    chk_lo("step_shift_y", 8'h81);
    expect_val("step_y0ym1_shift", 3); sb_check(int'(Y0YminusOne));

    for (int v = 0; v < 5; v++) run_mult(vecs[v], v);

    // Strobe conflicts and hold
    init_ops(8'h11, 8'h22);
    ldA = 1; aBarS = 0; tick();
    chk_hi("conf_add", 8'h11);
    initA = 1; ldA = 1; tick();
    chk_hi("conf_inita_lda", 0);
    inBus = 8'h5C; ldY = 1; shRY = 1; tick();
    chk_lo("conf_ldy_shry", 8'h5C);
    ldA = 1; tick();
    expect_val("conf_selL_selR", 8'h11);
    selL = 1; selR = 1; #1; sb_check(int'(outBus)); selL = 0; selR = 0; #1;
    inBus = 8'hA5;
    tick(); tick(); tick();
    expect_val("hold_idle_bus", 0); sb_check(int'(outBus));
    chk_hi("hold_a", 8'h11);
    chk_lo("hold_y", 8'h5C);
    expect_val("hold_y0ym1", 0); sb_check(int'(Y0YminusOne));
    expect_val("hold_co", 0); sb_check(int'(co));

    // Async reset mid-cycle with nonzero state and co high
    initC = 1; tick();
    for (int k = 0; k < N - 1; k++) begin icC = 1; tick(); end
    inBus = 8'hFF; ldY = 1; tick();
    expect_val("prerst_co", 1); sb_check(int'(co));
    expect_val("prerst_y0ym1", 2); sb_check(int'(Y0YminusOne));
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    expect_val("rst_co", 0); sb_check(int'(co));
    expect_val("rst_y0ym1", 0); sb_check(int'(Y0YminusOne));
    chk_hi("rst_hi", 0);
    chk_lo("rst_lo", 0);
    @(negedge clk);
    rst = 0;
    tick();
    chk_hi("postrst_hi", 0);
    chk_lo("postrst_lo", 0);

    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
